ifetch_queue: RTL and testbench

Instruction fetch stage sitting directly upstream of the CPU decode/execute stage. Issues sequential word fetches to instruction memory over a request/grant/response interface, buffers returned instructions with their PCs in a small FIFO, and presents them to the consumer over a valid/ready handshake. Branch/jump redirects from the execute stage flush the queue and squash in-flight responses.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 59 +++++
 rtl/ifetch_queue.sv | 100 ++++++++++
 tb/tb_ifetch_queue.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and constants for the instruction fetch queue
package riscv_pkg;

    // Fetch front-end mode: streaming requests, or waiting out squashed responses
    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One buffered instruction together with the address it was fetched from
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Force a byte address onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush, occupancy count and zeroed head when empty
module fetch_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [63:0]
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output T                         head
);

    localparam int              AW         = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_COUNT = (AW + 1)'(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_pop;

    assign do_pop = pop && (count != '0);

    // Storage is not reset; the head output is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; flush discards everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW + 1)'(push) - (AW + 1)'(do_pop);
        end
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

    // The upstream credit scheme must never let a push land on a full FIFO
    assert property (@(posedge clk) disable iff (reset) !(push && !flush && (count == FULL_COUNT)));

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - sequential instruction fetcher with credit-limited request issue and redirect squash
module ifetch_queue
    import riscv_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_e   state;
    logic [31:0]    fetch_pc;
    logic [CW-1:0]  outstanding;
    logic [CW-1:0]  discard;
    logic [CW-1:0]  count;
    logic [CW-1:0]  remaining;
    logic           credit;
    logic           grant;
    logic           accept_resp;
    fetch_entry_t   push_entry;
    fetch_entry_t   head;

    // Every slot is either buffered or promised to an in-flight request, so the FIFO cannot overflow
    assign credit      = ({1'b0, count} + {1'b0, outstanding}) < {1'b0, DEPTH_C};
    assign mem_req     = !reset && (state == FETCH) && credit && !redirect;
    assign mem_addr    = fetch_pc;
    assign grant       = mem_req && mem_gnt;
    assign accept_resp = mem_rvalid && (state == FETCH) && !redirect;

    // Responses are in order, so the oldest in-flight request sits outstanding words behind fetch_pc
    assign push_entry.pc    = fetch_pc - (32'(outstanding) << 2);
    assign push_entry.instr = mem_rdata;

    // In-flight count left once this cycle's response (if any) has retired
    assign remaining = outstanding - CW'(mem_rvalid);

    // Fetch PC, in-flight tracking and the FETCH/DRAIN sequencing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect) begin
            fetch_pc    <= word_align(redirect_pc);
            outstanding <= remaining;
            discard     <= remaining;
            state       <= (remaining != '0) ? DRAIN : FETCH;
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding + CW'(grant) - CW'(mem_rvalid);
            if ((state == DRAIN) && mem_rvalid) begin
                discard <= discard - CW'(1);
                if (discard == CW'(1)) begin
                    state <= FETCH;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept_resp),
        .push_data (push_entry),
        .pop       (out_valid && out_ready),
        .flush     (redirect),
        .count     (count),
        .head      (head)
    );

    assign out_valid = (count != '0);
    assign out_pc    = head.pc;
    assign out_instr = head.instr;

    // The low address bits of a redirect target carry no meaning for word fetches
    logic redirect_pc_unused;
    assign redirect_pc_unused = ^redirect_pc[1:0];

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - randomized scoreboard bench for the instruction fetch queue
module tb_ifetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_pc;
        int          epoch;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    req_t        pend[$];
    exp_t        sb[$];
    int          epoch = 0;
    logic [31:0] next_pc = 32'h0;
    int          tests = 0;
    int          fails = 0;
    int          pops = 0;
    int          p_gnt = 100, p_resp = 100, p_ready = 100, p_redir = 0;
    logic        force_redir = 1'b0;
    logic        force_combo = 1'b0;
    logic        combo_hit = 1'b0;
    logic        saw_wrap = 1'b0;
    logic [31:0] force_pc = 32'h0;
    logic [31:0] last_gnt_addr = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        #2;
        if (!reset) begin
            chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                pops++;
                chk("out_pc", out_pc, e.pc);
                chk("out_instr", out_instr, e.instr);
            end
        end
    end

    task automatic step();
        int   stale;
        logic exp_req;
        req_t r;
        @(negedge clk);
        mem_gnt    = ($urandom_range(99) < p_gnt);
        out_ready  = ($urandom_range(99) < p_ready);
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (pend.size() > 0 && $urandom_range(99) < p_resp) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pend[0].addr ^ KEY;
        end
        redirect = 1'b0;
        if (force_combo && pend.size() > 0 && sb.size() > 0) begin
            redirect    = 1'b1;
            redirect_pc = force_pc;
            mem_rvalid  = 1'b1;
            mem_rdata   = pend[0].addr ^ KEY;
            out_ready   = 1'b1;
            force_combo = 1'b0;
            combo_hit   = 1'b1;
        end else if (force_redir) begin
            redirect    = 1'b1;
            redirect_pc = force_pc;
            force_redir = 1'b0;
        end else if ($urandom_range(999) < p_redir) begin
            redirect    = 1'b1;
            redirect_pc = $urandom_range(1) ? $urandom : 32'($urandom_range(255));
        end
        #1;
        stale = 0;
        foreach (pend[i]) if (pend[i].epoch != epoch) stale++;
        exp_req = !redirect && (stale == 0) && (pend.size() + sb.size() < DEPTH);
        chk("mem_req", 32'(mem_req), 32'(exp_req));
        if (mem_req && exp_req) chk("mem_addr", mem_addr, next_pc);
        #2;
        if (mem_rvalid) begin
            r = pend.pop_front();
            if (!redirect && r.epoch == epoch) sb.push_back(exp_t'{r.exp_pc, r.exp_pc ^ KEY});
        end
        if (mem_req && mem_gnt) begin
            if (mem_addr == 32'h0 && last_gnt_addr == 32'hFFFF_FFFC) saw_wrap = 1'b1;
            last_gnt_addr = mem_addr;
            pend.push_back(req_t'{mem_addr, next_pc, epoch});
            next_pc += 32'd4;
        end
        if (redirect) begin
            epoch++;
            sb.delete();
            next_pc = {redirect_pc[31:2], 2'b00};
        end
    endtask

    initial begin
        int n;
        int pops0;
        #12;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Full-rate streaming from reset
        p_gnt = 100; p_resp = 100; p_ready = 100; p_redir = 0;
        pops0 = pops;
        repeat (30) step();
        chk("stream_throughput", 32'(pops - pops0), 32'd28);

        // Consumer stall fills the queue and throttles requests
        p_ready = 0;
        repeat (10) step();
        #1;
        chk("stall_mem_req", 32'(mem_req), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        p_ready = 100;
        repeat (10) step();

        // Redirect with three requests in flight
        p_resp = 0;
        n = 0;
        while (pend.size() != 3 && n < 50) begin
            step();
            n++;
        end
        chk("inflight3_wait", 32'(pend.size()), 32'd3);
        force_redir = 1'b1; force_pc = 32'h0000_0103; p_resp = 100;
        repeat (20) step();

        // Redirect coinciding with a response and a pop
        p_resp = 50;
        force_combo = 1'b1; force_pc = 32'h0000_0300;
        n = 0;
        while (!combo_hit && n < 100) begin
            step();
            n++;
        end
        chk("combo_wait", 32'(combo_hit), 32'd1);
        repeat (15) step();

        // Second redirect while still draining squashed responses
        p_resp = 0;
        repeat (3) step();
        force_redir = 1'b1; force_pc = 32'h0000_1000;
        step();
        force_redir = 1'b1; force_pc = 32'h0000_0200;
        step();
        p_resp = 100;
        repeat (20) step();

        // Address wrap at the top of the 32-bit space
        force_redir = 1'b1; force_pc = 32'hFFFF_FFF8;
        repeat (12) step();
        chk("addr_wrap", 32'(saw_wrap), 32'd1);

        // Randomized traffic
        for (int blk = 0; blk < 10; blk++) begin
            p_gnt   = $urandom_range(100, 30);
            p_resp  = $urandom_range(100, 30);
            p_ready = $urandom_range(100, 20);
            p_redir = $urandom_range(40);
            repeat (200) step();
        end

        // Asynchronous reset in the middle of traffic
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_mem_req", 32'(mem_req), 32'd0);
        pend.delete();
        sb.delete();
        epoch++;
        next_pc = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; redirect = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        p_gnt = 100; p_resp = 100; p_ready = 100; p_redir = 0;
        repeat (20) step();

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
